// File: rtl/rv_m_pkg.sv
// rtl/rv_m_pkg.sv - shared M-extension constants, op encodings and divider state type
package rv_m_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - request/result bundle between EX stage and the divider
interface iterative_divider_if;
  import rv_m_pkg::*;

  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] res_o;

  modport master (output start_i, op_i, a_i, b_i, flush_i,
                  input  busy_o, done_o, res_o);
  modport slave  (input  start_i, op_i, a_i, b_i, flush_i,
                  output busy_o, done_o, res_o);

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division iteration
module div_step
  import rv_m_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor on entry, so the shifted value fits XLEN+1 bits and the sign of diff decides
  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - RV32M DIV/DIVU/REM/REMU, one restoring quotient bit per cycle
module iterative_divider
  import rv_m_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  iterative_divider_if.slave bus
);

  div_state_t        state;
  logic              rem_sel;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   divisor;
  logic [2*XLEN-1:0] rq;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   res_q;

  logic            signed_op, rem_op, a_neg, b_neg, is_zero, is_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fix_res, quo, rem, step_rem;
  logic            step_q;

  assign signed_op = (bus.op_i == DIV_OP) || (bus.op_i == REM_OP);
  assign rem_op    = (bus.op_i == REM_OP) || (bus.op_i == REMU_OP);
  assign a_neg     = signed_op & bus.a_i[XLEN-1];
  assign b_neg     = signed_op & bus.b_i[XLEN-1];
  assign a_mag     = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag     = b_neg ? -bus.b_i : bus.b_i;
  assign is_zero   = (bus.b_i == '0);
  assign is_ovf    = signed_op && (bus.a_i == INT_MIN) && (bus.b_i == {XLEN{1'b1}});

  assign special_res = rem_op ? (is_zero ? bus.a_i : '0)
                              : (is_zero ? DIV_ZERO_Q : INT_MIN);

  assign rem     = rq[2*XLEN-1:XLEN];
  assign quo     = rq[XLEN-1:0];
  assign fix_res = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

  div_step u_step (
    .rem          (rem),
    .dividend_bit (rq[XLEN-1]),
    .divisor      (divisor),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divisor <= '0;
      rq      <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else if (bus.flush_i) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start_i) begin
            rem_sel <= rem_op;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            divisor <= b_mag;
            rq      <= {{XLEN{1'b0}}, a_mag};
            cnt     <= '0;
            if (is_zero || is_ovf) begin
              res_q  <= special_res;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          // remainder moves up into the high half as quotient bits shift in at the bottom
          rq  <= {step_rem, rq[XLEN-2:0], step_q};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          res_q  <= fix_res;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.res_o  = res_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
module tb_iterative_divider;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  iterative_divider_if dif ();

  iterative_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called #1 after an edge; counts edges from the one that samples start_i.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    lat = 0;
    dif.op_i    = op;
    dif.a_i     = a;
    dif.b_i     = b;
    dif.start_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        dif.start_i = 1'b0;
        n_cmp++;
        if (dif.busy_o !== (exp_lat > 1)) begin
          n_err++;
          $display("FAIL %s busy_after_accept: got %b want %b", name, dif.busy_o, exp_lat > 1);
        end
      end
      if (dif.done_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (dif.res_o !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", name, dif.res_o, exp_res,
               op, a, b);
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    dif.start_i = 1'b0;
    dif.flush_i = 1'b0;
    dif.op_i    = 2'b00;
    dif.a_i     = '0;
    dif.b_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({dif.busy_o, dif.done_o, dif.res_o} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b res=%h want 0/0/0", dif.busy_o, dif.done_o,
               dif.res_o);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    @(posedge clk); #1;
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34);
    @(posedge clk); #1;
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    @(posedge clk); #1;
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    @(posedge clk); #1;
    run_op("divu_by0", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    @(posedge clk); #1;
    run_op("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 1);
    @(posedge clk); #1;
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    @(posedge clk); #1;
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_and_back_to_back;
    int lat;
    int pulses;
    lat         = 0;
    pulses      = 0;
    dif.op_i    = 2'b01;
    dif.a_i     = 32'd100;
    dif.b_i     = 32'd7;
    dif.start_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      dif.start_i = 1'b0;
      if (i == 4) begin
        dif.a_i     = 32'd9;
        dif.b_i     = 32'd3;
        dif.start_i = 1'b1;
      end
      if (dif.done_o === 1'b1) begin
        pulses++;
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat != 34 || pulses != 1) begin
      n_err++;
      $display("FAIL ignore_start latency: got %0d (pulses %0d) want 34 (1)", lat, pulses);
    end
    n_cmp++;
    if (dif.res_o !== 32'd14) begin
      n_err++;
      $display("FAIL ignore_start result: got %h want %h", dif.res_o, 32'd14);
    end
    run_op("back_to_back", 2'b01, 32'd9, 32'd3, 32'd3, 34);
  endtask

  task automatic test_flush;
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    dif.op_i    = 2'b01;
    dif.a_i     = 32'd1000;
    dif.b_i     = 32'd10;
    dif.start_i = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      dif.start_i = 1'b0;
    end
    dif.flush_i = 1'b1;
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0;
    n_cmp++;
    if (dif.busy_o !== 1'b0 || dif.done_o !== 1'b0 || dif.res_o !== 32'd3) begin
      n_err++;
      $display("FAIL flush_state: busy=%b done=%b res=%h want 0/0/%h", dif.busy_o, dif.done_o,
               dif.res_o, 32'd3);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.done_o === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL flush_no_done: got %0d pulses want 0", pulses);
    end
    dif.start_i = 1'b1;
    dif.flush_i = 1'b1;
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    dif.flush_i = 1'b0;
    n_cmp++;
    if (dif.busy_o !== 1'b0 || dif.done_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_beats_start: busy=%b done=%b want 0/0", dif.busy_o, dif.done_o);
    end
  endtask

  task automatic test_async_reset;
    int pulses;
    pulses      = 0;
    dif.op_i    = 2'b01;
    dif.a_i     = 32'd500;
    dif.b_i     = 32'd3;
    dif.start_i = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      dif.start_i = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dif.busy_o, dif.done_o, dif.res_o} !== 34'd0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b done=%b res=%h want 0/0/0", dif.busy_o, dif.done_o,
               dif.res_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.done_o === 1'b1 || dif.busy_o === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL reset_lost_op: got %0d active cycles want 0", pulses);
    end
    run_op("after_reset", 2'b01, 32'd100, 32'd7, 32'd14, 34);
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("random", op, a, b, ref_div(op, a, b), ref_lat(op, a, b));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_ignore_and_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
